pong_match_sequencer: RTL and testbench
=======================================

// Module: pong_match_sequencer
// PURPOSE
//  Top-level match controller for the Pong datapath.
//  - Sequences serve, rally, point-hold and game-over phases.
//  - Owns both score registers and gates the ball/paddle physics through stop/serve_load.
//  - Enables the match countdown and declares the winner.
//  - Sits between the keypad/start button, the physics engine (miss1/miss2) and the score displays/LEDs.
// PARAMETERS
//  SCORE_W       3   width of each score register
//  WIN_SCORE     7   first player to reach this score wins (must be <= 2**SCORE_W-1)
//  SERVE_CYCLES  200 clk cycles spent in SERVE before the ball is released (>=1)
//  POINT_CYCLES  200 clk cycles spent in POINT after a miss (>=1)
//  OVER_CYCLES   200 minimum clk cycles in OVER before start is honoured (>=1)
// PORTS
//  clk         in   1        system clock
//  rst         in   1        synchronous, active-high reset
//  start       in   1        start button level; rising edge detected internally
//  miss1       in   1        level: player 1 missed the ball
//  miss2       in   1        level: player 2 missed the ball
//  time_up     in   1        level: match countdown reached 0:00
//  stop        out  1        1 = freeze ball/paddle physics
//  serve_load  out  1        1-cycle pulse: recentre the ball
//  serve_dir   out  1        0 = serve toward player 1, 1 = toward player 2
//  timer_run   out  1        enable for the match countdown
//  score1      out  SCORE_W  player 1 score
//  score2      out  SCORE_W  player 2 score
//  winner      out  2        00 none, 01 P1, 10 P2, 11 draw
//  state       out  3        encoding IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4 (for LEDs)
// BEHAVIOUR
//  - All outputs are registered. Reset values: state=IDLE, stop=1, serve_load=0, serve_dir=0,
//    timer_run=0, score1=score2=0, winner=00, hold counter=0.
//  - start_q samples start every cycle, including during rst. A button held through reset
//    therefore produces no edge. start_re = start & ~start_q.
//  - Hold counter is loaded on state entry. A state dwells exactly N cycles, then the next
//    state is entered.
//  - stop=0 and timer_run=1 only while state==PLAY; stop=1 in every other state.
//  - IDLE: scores and winner hold their last values.
//    - start_re -> SERVE; clear score1, score2, winner; serve_dir=0.
//  - SERVE: serve_load=1 during the first cycle in SERVE only.
//    - After SERVE_CYCLES cycles -> PLAY. miss1/miss2/start are ignored.
//  - PLAY, evaluated in priority order:
//    - miss1 & miss2 same cycle: no score change; serve_dir unchanged; -> POINT.
//    - miss1 only: score2+1; serve_dir=0 (serve toward the player who conceded).
//    - miss2 only: score1+1; serve_dir=1.
//    - After a scoring miss: if the new score == WIN_SCORE -> OVER, else -> POINT.
//    - time_up with no miss -> OVER.
//    - time_up in the same cycle as a miss: the score is applied first, then -> OVER.
//  - A miss level held for multiple cycles scores exactly once, because PLAY is left on the
//    next edge and misses are ignored outside PLAY.
//  - Scores never wrap; increments saturate at 2**SCORE_W-1.
//  - POINT: after POINT_CYCLES cycles -> OVER if time_up, else -> SERVE.
//  - OVER: winner is computed on entry from the final scores (greater wins; equal -> 11).
//    - start_re during the first OVER_CYCLES cycles is ignored.
//    - Afterwards start_re -> IDLE; scores and winner are retained for display.
//  - rst asserted in any state returns all registers to reset values on the next clk edge.
// TESTING (WIN_SCORE=3, SERVE/POINT/OVER_CYCLES=4)
//  1. Reset, then 1-cycle start -> next cycle state=1, serve_load=1 for 1 cycle, scores 0;
//     4 cycles later state=2, stop=0, timer_run=1.
//  2. In PLAY hold miss1 for 3 cycles -> score2=1 exactly once, state=3, serve_dir=0, stop=1;
//     after 4 cycles state=1 with serve_load pulse.
//  3. Three separate miss2 rallies -> score1=3, state=4, winner=01;
//     start at OVER cycle 2 is ignored; start at cycle 6 -> state=0, score1 still 3.
//  4. miss1 & miss2 same cycle at scores 1:2 -> scores stay 1:2, state=3, serve_dir unchanged.
//  5. time_up at scores 2:2 -> state=4, winner=11;
//     repeat at 1:1 with time_up+miss2 same cycle -> score1=2, state=4, winner=01.
//  6. rst for 1 cycle mid-PLAY with start held high -> reset values next cycle;
//     no SERVE entry until start is released and pressed again.

Source files
------------

// File: rtl/pong_match_sequencer.sv
// pong_match_sequencer
//   Match controller for the Pong datapath. Steps through the serve, rally,
//   point-hold and game-over phases, owns both score registers, gates the
//   ball/paddle physics and the match countdown, and declares the winner.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   start               start button level (rising edge detected internally)
//   miss1, miss2        level: player 1 / player 2 missed the ball
//   time_up             level: match countdown expired
//   stop                1 = freeze ball/paddle physics (0 only in PLAY)
//   serve_load          1-cycle pulse on SERVE entry: recentre the ball
//   serve_dir           0 = serve toward player 1, 1 = toward player 2
//   timer_run           match countdown enable (1 only in PLAY)
//   score1, score2      player scores, saturating
//   winner              00 none, 01 P1, 10 P2, 11 draw
//   state               IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
module pong_match_sequencer #(
   parameter int unsigned SCORE_W      = 3,
   parameter int unsigned WIN_SCORE    = 7,
   parameter int unsigned SERVE_CYCLES = 200,
   parameter int unsigned POINT_CYCLES = 200,
   parameter int unsigned OVER_CYCLES  = 200
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               miss1,
   input  logic               miss2,
   input  logic               time_up,
   output logic               stop,
   output logic               serve_load,
   output logic               serve_dir,
   output logic               timer_run,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [1:0]         winner,
   output logic [2:0]         state
);

   localparam int unsigned MAX_SP  = (SERVE_CYCLES > POINT_CYCLES) ? SERVE_CYCLES : POINT_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_SP > OVER_CYCLES) ? MAX_SP : OVER_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

   // SERVE/POINT count down N-1..0 and leave on the zero cycle (exactly N cycles).
   // OVER loads N so start is only honoured from cycle N+1 onward.
   localparam logic [CNT_W-1:0] SERVE_LD = CNT_W'(SERVE_CYCLES - 1);
   localparam logic [CNT_W-1:0] POINT_LD = CNT_W'(POINT_CYCLES - 1);
   localparam logic [CNT_W-1:0] OVER_LD  = CNT_W'(OVER_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_POINT = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
   logic [1:0]         winner_q, winner_d;
   logic               dir_q, dir_d;
   logic               load_q, load_d;
   logic               stop_q, run_q;
   logic               start_q, start_re;
   logic               won;

   function automatic logic [SCORE_W-1:0] inc_sat(input logic [SCORE_W-1:0] v);
      return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
   endfunction

   function automatic logic [1:0] judge(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
      if (a > b) return 2'b01;
      if (b > a) return 2'b10;
      return 2'b11;
   endfunction

   assign start_re = start & ~start_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      score1_d = score1_q;
      score2_d = score2_q;
      winner_d = winner_q;
      dir_d    = dir_q;
      load_d   = 1'b0;
      won      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_re) begin
               state_d  = S_SERVE;
               cnt_d    = SERVE_LD;
               score1_d = '0;
               score2_d = '0;
               winner_d = '0;
               dir_d    = 1'b0;
               load_d   = 1'b1;
            end
         end
         S_SERVE: begin
            if (cnt_q == '0) state_d = S_PLAY;
            else             cnt_d   = cnt_q - CNT_ONE;
         end
         S_PLAY: begin
            if (miss1 && miss2) begin
               state_d = S_POINT;
               cnt_d   = POINT_LD;
            end else if (miss1 || miss2) begin
               if (miss1) begin
                  score2_d = inc_sat(score2_q);
                  dir_d    = 1'b0;
                  won      = (score2_d == WIN);
               end else begin
                  score1_d = inc_sat(score1_q);
                  dir_d    = 1'b1;
                  won      = (score1_d == WIN);
               end
               // Winner is judged on the post-increment scores.
               if (time_up || won) begin
                  state_d  = S_OVER;
                  cnt_d    = OVER_LD;
                  winner_d = judge(score1_d, score2_d);
               end else begin
                  state_d = S_POINT;
                  cnt_d   = POINT_LD;
               end
            end else if (time_up) begin
               state_d  = S_OVER;
               cnt_d    = OVER_LD;
               winner_d = judge(score1_q, score2_q);
            end
         end
         S_POINT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (time_up) begin
               state_d  = S_OVER;
               cnt_d    = OVER_LD;
               winner_d = judge(score1_q, score2_q);
            end else begin
               state_d = S_SERVE;
               cnt_d   = SERVE_LD;
               load_d  = 1'b1;
            end
         end
         S_OVER: begin
            if (cnt_q != '0)   cnt_d   = cnt_q - CNT_ONE;
            else if (start_re) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // Sampled through reset so a button held across reset yields no edge.
      start_q <= start;
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         score1_q <= '0;
         score2_q <= '0;
         winner_q <= '0;
         dir_q    <= 1'b0;
         load_q   <= 1'b0;
         stop_q   <= 1'b1;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         score1_q <= score1_d;
         score2_q <= score2_d;
         winner_q <= winner_d;
         dir_q    <= dir_d;
         load_q   <= load_d;
         stop_q   <= (state_d != S_PLAY);
         run_q    <= (state_d == S_PLAY);
      end
   end

   assign state      = state_q;
   assign stop       = stop_q;
   assign timer_run  = run_q;
   assign serve_load = load_q;
   assign serve_dir  = dir_q;
   assign score1     = score1_q;
   assign score2     = score2_q;
   assign winner     = winner_q;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// tb_pong_match_sequencer
//   Scenario tasks for pong_match_sequencer with WIN_SCORE=3 and all phase
//   lengths 4, followed by a randomized run checked against a phase/elapsed-
//   cycle reference model of the match rules.
module tb_pong_match_sequencer;

   localparam int SW  = 3;
   localparam int WIN = 3;
   localparam int NC  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1, start = 1'b0, miss1 = 1'b0, miss2 = 1'b0, time_up = 1'b0;
   logic          stop, serve_load, serve_dir, timer_run;
   logic [SW-1:0] score1, score2;
   logic [1:0]    winner;
   logic [2:0]    state;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: phase number, cycles elapsed since phase entry
   int m_ph = 0, m_el = 0, m_s1 = 0, m_s2 = 0, m_win = 0, m_dir = 0, m_load = 0, m_sq = 0;

   always #5 clk = ~clk;

   pong_match_sequencer #(
      .SCORE_W(SW), .WIN_SCORE(WIN),
      .SERVE_CYCLES(NC), .POINT_CYCLES(NC), .OVER_CYCLES(NC)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .miss1(miss1), .miss2(miss2), .time_up(time_up),
      .stop(stop), .serve_load(serve_load), .serve_dir(serve_dir), .timer_run(timer_run),
      .score1(score1), .score2(score2), .winner(winner), .state(state)
   );

   function automatic int judge(input int a, input int b);
      if (a > b) return 1;
      if (b > a) return 2;
      return 3;
   endfunction

   task automatic model_edge(input bit r, input bit s, input bit a, input bit b, input bit t);
      bit sre;
      int smax;
      smax = (1 << SW) - 1;
      sre  = s && (m_sq == 0);
      m_sq = s;
      if (r) begin
         m_ph = 0; m_el = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; m_load = 0;
         return;
      end
      m_load = 0;
      m_el++;
      case (m_ph)
         0: if (sre) begin
               m_ph = 1; m_el = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; m_load = 1;
            end
         1: if (m_el == NC) begin m_ph = 2; m_el = 0; end
         2: begin
            if (a && b) begin
               m_ph = 3; m_el = 0;
            end else if (a || b) begin
               if (a) begin m_s2 = (m_s2 + 1 > smax) ? smax : m_s2 + 1; m_dir = 0; end
               else   begin m_s1 = (m_s1 + 1 > smax) ? smax : m_s1 + 1; m_dir = 1; end
               m_el = 0;
               if (t || m_s1 == WIN || m_s2 == WIN) begin m_ph = 4; m_win = judge(m_s1, m_s2); end
               else m_ph = 3;
            end else if (t) begin
               m_ph = 4; m_el = 0; m_win = judge(m_s1, m_s2);
            end
         end
         3: if (m_el == NC) begin
               m_el = 0;
               if (t) begin m_ph = 4; m_win = judge(m_s1, m_s2); end
               else   begin m_ph = 1; m_load = 1; end
            end
         4: if (m_el > NC && sre) begin m_ph = 0; m_el = 0; end
         default: m_ph = 0;
      endcase
   endtask

   task automatic step(input bit r, input bit s, input bit a, input bit b, input bit t);
      rst = r; start = s; miss1 = a; miss2 = b; time_up = t;
      @(posedge clk);
      model_edge(r, s, a, b, t);
      #1;
   endtask

   task automatic go_play();
      for (int i = 0; i < 40 && m_ph != 2; i++) step(0, 0, 0, 0, 0);
      n_chk++;
      if (state !== 3'd2) $display("FAIL go_play state got %0d want 2", state);
      else n_pass++;
   endtask

   // wait a random few PLAY cycles, then apply one miss/time_up pattern
   task automatic rally(input bit a, input bit b, input bit t);
      go_play();
      repeat ($urandom_range(0, 3)) step(0, 0, 0, 0, 0);
      step(0, 0, a, b, t);
   endtask

   task automatic leave_over();
      repeat (NC + 1) step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      n_chk++;
      if ({state, stop, serve_load, serve_dir, timer_run} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0})
         $display("FAIL reset_ctrl got st=%0d stop=%b ld=%b dir=%b run=%b want 0 1 0 0 0",
                  state, stop, serve_load, serve_dir, timer_run);
      else n_pass++;
      n_chk++;
      if ({score1, score2, winner} !== '0)
         $display("FAIL reset_score got s1=%0d s2=%0d win=%0d want 0 0 0", score1, score2, winner);
      else n_pass++;
      step(0, 0, 0, 0, 0);
   endtask

   task automatic test_serve();
      step(0, 1, 0, 0, 0);
      n_chk++;
      if ({state, serve_load, stop, score1, score2} !== {3'd1, 1'b1, 1'b1, 3'd0, 3'd0})
         $display("FAIL serve_entry got st=%0d ld=%b stop=%b s=%0d:%0d want 1 1 1 0:0",
                  state, serve_load, stop, score1, score2);
      else n_pass++;
      step(0, 0, 0, 0, 0);
      n_chk++;
      if (serve_load !== 1'b0) $display("FAIL serve_pulse got %b want 0", serve_load);
      else n_pass++;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      n_chk++;
      if (state !== 3'd1) $display("FAIL serve_dwell got %0d want 1", state);
      else n_pass++;
      step(0, 0, 0, 0, 0);
      n_chk++;
      if ({state, stop, timer_run} !== {3'd2, 1'b0, 1'b1})
         $display("FAIL serve_to_play got st=%0d stop=%b run=%b want 2 0 1", state, stop, timer_run);
      else n_pass++;
   endtask

   task automatic test_miss_hold();
      step(0, 0, 1, 0, 0);
      n_chk++;
      if ({score2, state, serve_dir, stop} !== {3'd1, 3'd3, 1'b0, 1'b1})
         $display("FAIL miss1_point got s2=%0d st=%0d dir=%b stop=%b want 1 3 0 1",
                  score2, state, serve_dir, stop);
      else n_pass++;
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      n_chk++;
      if ({score2, state} !== {3'd1, 3'd3})
         $display("FAIL miss1_once got s2=%0d st=%0d want 1 3", score2, state);
      else n_pass++;
      step(0, 0, 0, 0, 0);
      n_chk++;
      if (state !== 3'd3) $display("FAIL point_dwell got %0d want 3", state);
      else n_pass++;
      step(0, 0, 0, 0, 0);
      n_chk++;
      if ({state, serve_load} !== {3'd1, 1'b1})
         $display("FAIL point_to_serve got st=%0d ld=%b want 1 1", state, serve_load);
      else n_pass++;
   endtask

   task automatic test_win_over();
      for (int k = 1; k <= 3; k++) begin
         rally(0, 1, 0);
         n_chk++;
         if (score1 !== SW'(k)) $display("FAIL p1_score got %0d want %0d", score1, k);
         else n_pass++;
      end
      n_chk++;
      if ({state, winner, score2} !== {3'd4, 2'b01, 3'd1})
         $display("FAIL p1_wins got st=%0d win=%0d s2=%0d want 4 1 1", state, winner, score2);
      else n_pass++;
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      n_chk++;
      if (state !== 3'd4) $display("FAIL over_early_start got %0d want 4", state);
      else n_pass++;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      n_chk++;
      if ({state, score1, winner} !== {3'd0, 3'd3, 2'b01})
         $display("FAIL over_to_idle got st=%0d s1=%0d win=%0d want 0 3 1", state, score1, winner);
      else n_pass++;
      step(0, 0, 0, 0, 0);
   endtask

   task automatic test_double_miss();
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      rally(1, 0, 0);
      rally(1, 0, 0);
      rally(0, 1, 0);
      go_play();
      step(0, 0, 1, 1, 0);
      n_chk++;
      if ({score1, score2, state, serve_dir} !== {3'd1, 3'd2, 3'd3, 1'b1})
         $display("FAIL double_miss got %0d:%0d st=%0d dir=%b want 1:2 3 1",
                  score1, score2, state, serve_dir);
      else n_pass++;
      rally(1, 0, 0);
      n_chk++;
      if ({state, winner, score2} !== {3'd4, 2'b10, 3'd3})
         $display("FAIL p2_wins got st=%0d win=%0d s2=%0d want 4 2 3", state, winner, score2);
      else n_pass++;
      leave_over();
   endtask

   task automatic test_time_up();
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      rally(0, 1, 0);
      rally(1, 0, 0);
      rally(0, 1, 0);
      rally(1, 0, 0);
      rally(0, 0, 1);
      n_chk++;
      if ({state, winner, score1, score2} !== {3'd4, 2'b11, 3'd2, 3'd2})
         $display("FAIL time_up_draw got st=%0d win=%0d %0d:%0d want 4 3 2:2",
                  state, winner, score1, score2);
      else n_pass++;
      leave_over();
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      rally(0, 1, 0);
      rally(1, 0, 0);
      rally(0, 1, 1);
      n_chk++;
      if ({score1, score2, state, winner} !== {3'd2, 3'd1, 3'd4, 2'b01})
         $display("FAIL time_up_miss got %0d:%0d st=%0d win=%0d want 2:1 4 1",
                  score1, score2, state, winner);
      else n_pass++;
      leave_over();
   endtask

   task automatic test_reset_mid_play();
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      go_play();
      step(1, 1, 0, 0, 0);
      n_chk++;
      if ({state, stop, timer_run, score1, score2} !== {3'd0, 1'b1, 1'b0, 3'd0, 3'd0})
         $display("FAIL rst_mid_play got st=%0d stop=%b run=%b %0d:%0d want 0 1 0 0:0",
                  state, stop, timer_run, score1, score2);
      else n_pass++;
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      n_chk++;
      if (state !== 3'd0) $display("FAIL held_start got %0d want 0", state);
      else n_pass++;
      step(0, 1, 0, 0, 0);
      n_chk++;
      if ({state, serve_load} !== {3'd1, 1'b1})
         $display("FAIL repress_start got st=%0d ld=%b want 1 1", state, serve_load);
      else n_pass++;
      step(0, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      logic [14:0] got, exp;
      bit r, s, a, b, t;
      int bad = 0;
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom % 400) == 0;
         s = ($urandom % 6) == 0;
         a = ($urandom % 8) == 0;
         b = ($urandom % 8) == 0;
         t = ($urandom % 40) == 0;
         if (a && b) t = 1'b0;
         step(r, s, a, b, t);
         got = {state, stop, serve_load, serve_dir, timer_run, score1, score2, winner};
         exp = {3'(m_ph), 1'(m_ph != 2), 1'(m_load), 1'(m_dir), 1'(m_ph == 2),
                SW'(m_s1), SW'(m_s2), 2'(m_win)};
         n_chk++;
         if (got !== exp) begin
            if (bad < 10)
               $display("FAIL random cyc=%0d got %h want %h", i, got, exp);
            bad++;
         end else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_serve();
      test_miss_hold();
      test_win_over();
      test_double_miss();
      test_time_up();
      test_reset_mid_play();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

endmodule
